sr_latch_checker: RTL
=====================

# sr_latch_checker

Synthesizable response checker for the SR latch: the receiving end of the latch's S/R stimulus interface. It samples the S/R pair driven into the latch under test and the Q/Q_bar pair coming back out. For every stable S/R pair it waits a programmable settle time, then compares Q/Q_bar against an internal reference model. Mismatches, forbidden-input events and check counts are reported as registered pulses and saturating counters, so latch benches and on-board self-test share one pass/fail source.

## Interface
Parameters:
- SETTLE_CYC, 2, clock cycles waited after a new S/R pair before Q/Q_bar are compared (legal range 1..255)
- CNT_W, 8, width of all event counters

Ports:
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  checking enable; 0 freezes the FSM in IDLE and holds all counters
- s  in  1  S input as driven to the latch under test
- r  in  1  R input as driven to the latch under test
- q  in  1  latch Q output
- q_bar  in  1  latch Q_bar output
- exp_q  out  1  reference-model Q value
- exp_valid  out  1  1 when exp_q is defined; 0 after a forbidden pair until the next set or reset
- mismatch  out  1  one-cycle pulse: the completed check failed
- invalid  out  1  one-cycle pulse: the completed check was the forbidden pair S=R=1
- chk_cnt  out  CNT_W  checks performed, saturating
- err_cnt  out  CNT_W  mismatches, saturating
- inv_cnt  out  CNT_W  forbidden pairs, saturating

## Operation
- Input stage: s, r, q, q_bar are registered every cycle into s_d, r_d, q_d, qb_d. All decisions use the registered copies. Inputs are synchronous to clk; the caller handles synchronization.
- Captured pair cap_sr holds the last S/R pair accepted for checking. It resets to 2'b00.
- Reference model, applied to cap_sr when a check completes:
  - 00: hold exp_q.
  - 01: exp_q=0, exp_valid=1.
  - 10: exp_q=1, exp_valid=1.
  - 11: exp_valid=0; exp_q is unchanged but meaningless.
- Check rules in CHECK:
  - Pair 11: assert invalid, increment inv_cnt, suppress mismatch. The forbidden state is discounted, not an error.
  - Pair 00 with exp_valid=0: no comparison and no mismatch; chk_cnt still increments.
  - Otherwise: mismatch = (q_d != exp_q) OR (qb_d != ~q_d).
  - chk_cnt increments on every CHECK. err_cnt increments on every mismatch.
  - All counters saturate at 2^CNT_W-1.
- FSM states:
  - IDLE: entered when en=0.
  - WAIT: inputs stable.
  - SETTLE: settle counter running.
  - CHECK: exactly one cycle.
- FSM transitions:
  - IDLE→WAIT when en=1. cap_sr is loaded with {s_d,r_d} and a check is forced (goes to SETTLE).
  - WAIT→SETTLE when {s_d,r_d} != cap_sr. cap_sr is loaded and the settle counter is set to SETTLE_CYC.
  - SETTLE: counter decrements each cycle; at 0 the FSM goes to CHECK.
  - SETTLE with a new pair: cap_sr reloads and the counter restarts (retrigger); no check is issued for the superseded pair.
  - CHECK→SETTLE if the pair changed during the CHECK cycle; the new pair is loaded. Otherwise CHECK→WAIT.
  - Any state→IDLE when en=0. mismatch/invalid are forced low; counters, exp_q and exp_valid hold.
- Reset values: state IDLE, cap_sr 00, exp_q 0, exp_valid 0, mismatch 0, invalid 0, all counters 0.
- Reset mid-operation returns to these values on the next edge. A pending check is discarded.

## Timing
- Let edge N be the first clock at which a new s/r value lands in s_d/r_d.
- Edge N+1: FSM enters SETTLE.
- Edge N+1+SETTLE_CYC: FSM enters CHECK.
- mismatch/invalid/counter updates/exp_q become visible after edge N+2+SETTLE_CYC and last one cycle.
- Total latency from the stimulus sample edge to the result is SETTLE_CYC+2 cycles; with the default this is 4.
- q/q_bar are compared as sampled into q_d/qb_d at the CHECK cycle.
- Back-to-back pairs need at least SETTLE_CYC+2 cycles of stability each to be individually checked.

## Structure
- Shared package sr_pkg holds:
  - state enum: IDLE, WAIT, SETTLE, CHECK
  - SR pair constants: SR_HOLD=2'b00, SR_RESET=2'b01, SR_SET=2'b10, SR_FORBID=2'b11
  - the function computing next exp_q/exp_valid from a pair
- One natural sub-module: sat_counter (parameter W, inc input, synchronous clear), instantiated three times.

## Test plan
- Reset, en=1, s=0 r=0 held: one forced check at cycle 4; chk_cnt=1, mismatch=0 (exp_valid=0), exp_q=0.
- Drive 10 with a correct latch (q=1, q_bar=0), then 01 (q=0, q_bar=1): chk_cnt=3, err_cnt=0, exp_q follows 1 then 0.
- Drive 11 with q=0, q_bar=0: invalid pulses once, inv_cnt=1, err_cnt unchanged. Then drive 00: no mismatch while exp_valid=0.
- Drive 10 while q is stuck at 0: mismatch pulses 4 cycles after the sample edge, err_cnt=1. Repeat 300 times with CNT_W=8: err_cnt saturates at 255.
- Toggle s every cycle for 10 cycles, then hold: only one check, for the final pair (retrigger). Pulse rst=1 in SETTLE: all outputs 0 next cycle and no check is issued.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared types, S/R pair encodings and the latch reference model for the SR latch checker.
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_e;

    localparam logic [1:0] SR_HOLD   = 2'b00;
    localparam logic [1:0] SR_RESET  = 2'b01;
    localparam logic [1:0] SR_SET    = 2'b10;
    localparam logic [1:0] SR_FORBID = 2'b11;

    typedef struct packed {
        logic q;
        logic valid;
    } ref_t;

    // Forbidden pair keeps the old q bit but marks it meaningless.
    function automatic ref_t sr_model(input logic [1:0] pair, input ref_t cur);
        ref_t nxt;
        nxt = cur;
        case (pair)
            SR_RESET: begin
                nxt.q     = 1'b0;
                nxt.valid = 1'b1;
            end
            SR_SET: begin
                nxt.q     = 1'b1;
                nxt.valid = 1'b1;
            end
            SR_FORBID: nxt.valid = 1'b0;
            default:   nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_latch_checker_sat_counter.sv
// Saturating event counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/sr_latch_checker.sv
// Checks latch Q/Q_bar against a reference model SETTLE_CYC cycles after each stable S/R pair.
// Result pulses and counters appear SETTLE_CYC+2 cycles after the stimulus is registered.
module sr_latch_checker
    import sr_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             q_bar,
    output logic             exp_q,
    output logic             exp_valid,
    output logic             mismatch,
    output logic             invalid,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] inv_cnt
);

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC);

    logic       s_q, r_q, q_q, qb_q;
    state_e     state_q, state_d;
    logic [1:0] cap_q, cap_d;
    logic [7:0] cnt_q, cnt_d;
    logic       force_q, force_d;
    ref_t       ref_q, ref_d;
    logic       mismatch_q, mismatch_d;
    logic       invalid_q, invalid_d;
    logic       chk_inc, err_inc, inv_inc;
    logic [1:0] pair;
    ref_t       ref_nxt;

    assign pair    = {s_q, r_q};
    assign ref_nxt = sr_model(cap_q, ref_q);

    always_comb begin
        state_d    = state_q;
        cap_d      = cap_q;
        cnt_d      = cnt_q;
        force_d    = force_q;
        ref_d      = ref_q;
        mismatch_d = 1'b0;
        invalid_d  = 1'b0;
        chk_inc    = 1'b0;
        err_inc    = 1'b0;
        inv_inc    = 1'b0;

        if (!en) begin
            state_d = IDLE;
            force_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Leaving IDLE always checks the current pair, even if unchanged.
                    state_d = WAIT;
                    cap_d   = pair;
                    force_d = 1'b1;
                end
                WAIT: begin
                    if ((pair != cap_q) || force_q) begin
                        state_d = SETTLE;
                        cap_d   = pair;
                        cnt_d   = SETTLE_LD;
                        force_d = 1'b0;
                    end
                end
                SETTLE: begin
                    if (pair != cap_q) begin
                        cap_d = pair;
                        cnt_d = SETTLE_LD;
                    end else if (cnt_q <= 8'd1) begin
                        cnt_d   = 8'd0;
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                CHECK: begin
                    chk_inc = 1'b1;
                    ref_d   = ref_nxt;
                    if (cap_q == SR_FORBID) begin
                        invalid_d = 1'b1;
                        inv_inc   = 1'b1;
                    end else if (!((cap_q == SR_HOLD) && !ref_q.valid)) begin
                        mismatch_d = (q_q != ref_nxt.q) || (qb_q != ~q_q);
                        err_inc    = mismatch_d;
                    end
                    if (pair != cap_q) begin
                        state_d = SETTLE;
                        cap_d   = pair;
                        cnt_d   = SETTLE_LD;
                    end else begin
                        state_d = WAIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            q_q        <= 1'b0;
            qb_q       <= 1'b0;
            state_q    <= IDLE;
            cap_q      <= SR_HOLD;
            cnt_q      <= 8'd0;
            force_q    <= 1'b0;
            ref_q      <= '0;
            mismatch_q <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            s_q        <= s;
            r_q        <= r;
            q_q        <= q;
            qb_q       <= q_bar;
            state_q    <= state_d;
            cap_q      <= cap_d;
            cnt_q      <= cnt_d;
            force_q    <= force_d;
            ref_q      <= ref_d;
            mismatch_q <= mismatch_d;
            invalid_q  <= invalid_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_chk_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (chk_inc),
        .cnt_o (chk_cnt)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (err_inc),
        .cnt_o (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_inv_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (inv_inc),
        .cnt_o (inv_cnt)
    );

    assign exp_q     = ref_q.q;
    assign exp_valid = ref_q.valid;
    assign mismatch  = mismatch_q;
    assign invalid   = invalid_q;

endmodule
